// File: rtl/ppu_instr_encoder_pkg.sv
// Opcode map and PPU op encoding shared by the encoder and its FIFO.
// Holds ppu_op_e, funct fields and the ppu_encode() helper.
package zeroriscy_defines;
    localparam logic [6:0] OPCODE_PPU_OP = 7'h0b;
endpackage

package ppu_encoder_defines;
    import zeroriscy_defines::*;

    typedef enum logic [3:0] {
        PPU_ADD     = 4'd0,
        PPU_SUB     = 4'd1,
        PPU_MUL     = 4'd2,
        PPU_DIV     = 4'd3,
        PPU_FMADD_S = 4'd4,
        PPU_FMADD_C = 4'd5,
        PPU_F2P     = 4'd6,
        PPU_P2F     = 4'd7
    } ppu_op_e;

    localparam logic [6:0] FUNCT7_PPU_ARITH   = 7'b1101010;
    localparam logic [6:0] FUNCT7_PPU_FMADD_S = 7'b1101100;
    localparam logic [6:0] FUNCT7_PPU_FMADD_C = 7'b1101101;
    localparam logic [6:0] FUNCT7_PPU_F2P     = 7'b1101000;
    localparam logic [6:0] FUNCT7_PPU_P2F     = 7'b1101001;

    localparam logic [2:0] FUNCT3_PPU_ADD  = 3'b000;
    localparam logic [2:0] FUNCT3_PPU_SUB  = 3'b001;
    localparam logic [2:0] FUNCT3_PPU_MUL  = 3'b010;
    localparam logic [2:0] FUNCT3_PPU_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_PPU_NONE = 3'b000;

    function automatic logic ppu_legal(input logic [3:0] op);
        return !op[3];
    endfunction

    function automatic logic [31:0] ppu_encode(
        input logic [3:0] op,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        logic [6:0] f7;
        logic [2:0] f3;
        logic [4:0] r2;
        f7 = FUNCT7_PPU_ARITH;
        f3 = FUNCT3_PPU_NONE;
        r2 = rs2;
        case (op)
            PPU_ADD:     f3 = FUNCT3_PPU_ADD;
            PPU_SUB:     f3 = FUNCT3_PPU_SUB;
            PPU_MUL:     f3 = FUNCT3_PPU_MUL;
            PPU_DIV:     f3 = FUNCT3_PPU_DIV;
            PPU_FMADD_S: f7 = FUNCT7_PPU_FMADD_S;
            PPU_FMADD_C: f7 = FUNCT7_PPU_FMADD_C;
            PPU_F2P: begin
                f7 = FUNCT7_PPU_F2P;
                r2 = 5'd0;
            end
            PPU_P2F: begin
                f7 = FUNCT7_PPU_P2F;
                r2 = 5'd0;
            end
            default: f7 = 7'd0;
        endcase
        return {f7, r2, rs1, f3, rd, OPCODE_PPU_OP};
    endfunction
endpackage

// File: rtl/ppu_instr_encoder_fifo.sv
// Synchronous first-word-fall-through FIFO, DEPTH x W.
// Head is always visible on rdata while not empty.
module ppu_instr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign rdata   = mem[rptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop)
                rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/ppu_instr_encoder.sv
// Encodes PPU op commands into RV32 words and queues them
// for the fetch stub over a valid/ready port.
module ppu_instr_encoder
    import ppu_encoder_defines::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [3:0]       cmd_op_i,
    input  logic [4:0]       cmd_rd_i,
    input  logic [4:0]       cmd_rs1_i,
    input  logic [4:0]       cmd_rs2_i,
    output logic             instr_valid_o,
    input  logic             instr_ready_i,
    output logic [31:0]      instr_rdata_o,
    output logic             illegal_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    logic        full;
    logic        empty;
    logic        accept;
    logic        legal;
    logic        push;
    logic        pop;
    logic [31:0] word;

    assign cmd_ready_o   = !full && !flush_i;
    assign accept        = cmd_valid_i && cmd_ready_o;
    assign legal         = ppu_legal(cmd_op_i);
    assign push          = accept && legal;
    assign instr_valid_o = !empty && !flush_i;
    assign pop           = instr_valid_o && instr_ready_i;
    assign empty_o       = empty;
    assign word          = ppu_encode(cmd_op_i, cmd_rd_i,
                                      cmd_rs1_i, cmd_rs2_i);

    ppu_instr_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_i),
        .push  (push),
        .wdata (word),
        .pop   (pop),
        .rdata (instr_rdata_o),
        .full  (full),
        .empty (empty)
    );

    // Flush deliberately leaves the counter and a pending pulse alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_o <= 1'b0;
            count_o   <= '0;
        end else begin
            illegal_o <= accept && !legal;
            if (pop)
                count_o <= count_o + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_ppu_instr_encoder.sv
// Randomized bench for ppu_instr_encoder against a queue-based model.
// Directed literals pin encoding, full/flush/illegal and counter wrap.
module tb_ppu_instr_encoder;
    import zeroriscy_defines::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, flush_i, cmd_valid_i, instr_ready_i;
    logic [3:0]  cmd_op_i;
    logic [4:0]  cmd_rd_i, cmd_rs1_i, cmd_rs2_i;
    logic        cmd_ready_o, instr_valid_o, illegal_o, empty_o;
    logic [31:0] instr_rdata_o;
    logic [15:0] count_o;

    int          total = 0;
    int          bad = 0;
    logic [31:0] q[$];
    logic [15:0] m_cnt;
    bit          m_ill;

    always #5 clk = ~clk;

    ppu_instr_encoder #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_op_i      (cmd_op_i),
        .cmd_rd_i      (cmd_rd_i),
        .cmd_rs1_i     (cmd_rs1_i),
        .cmd_rs2_i     (cmd_rs2_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_rdata_o (instr_rdata_o),
        .illegal_o     (illegal_o),
        .empty_o       (empty_o),
        .count_o       (count_o)
    );

    function automatic logic [31:0] ref_word(int op, int rd, int rs1, int rs2);
        int f7[8] = '{106, 106, 106, 106, 108, 109, 104, 105};
        int f3[8] = '{0, 1, 2, 4, 0, 0, 0, 0};
        int r2;
        r2 = (op >= 6) ? 0 : rs2;
        return (32'(f7[op]) << 25) + (32'(r2) << 20) + (32'(rs1) << 15)
             + (32'(f3[op]) << 12) + (32'(rd) << 7) + 32'(OPCODE_PPU_OP);
    endfunction

    function automatic int mask_hits(logic [31:0] w);
        int n = 0;
        logic [31:0] m;
        for (int k = 0; k < 8; k++) begin
            m = (k >= 6) ? 32'hFFF0707F : 32'hFE00707F;
            if ((w & m) == ref_word(k, 0, 0, 0))
                n++;
        end
        return n;
    endfunction

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check();
        bit mr, mv;
        mr = (q.size() < DEPTH) && !flush_i;
        mv = (q.size() > 0) && !flush_i;
        cmp("cmd_ready", 32'(cmd_ready_o), 32'(mr));
        cmp("instr_valid", 32'(instr_valid_o), 32'(mv));
        cmp("empty", 32'(empty_o), 32'(q.size() == 0));
        cmp("illegal", 32'(illegal_o), 32'(m_ill));
        cmp("count", 32'(count_o), 32'(m_cnt));
        if (mv) begin
            cmp("rdata", instr_rdata_o, q[0]);
            cmp("mask_hits", 32'(mask_hits(instr_rdata_o)), 32'd1);
        end
    endtask

    task automatic step(bit r, bit fl, bit cv, int op, int rd,
                        int rs1, int rs2, bit ir, bit chk);
        bit rdy, vld;
        rst = r;
        flush_i = fl;
        cmd_valid_i = cv;
        cmd_op_i = 4'(op);
        cmd_rd_i = 5'(rd);
        cmd_rs1_i = 5'(rs1);
        cmd_rs2_i = 5'(rs2);
        instr_ready_i = ir;
        #1;
        if (chk)
            check();
        @(posedge clk);
        if (r) begin
            q.delete();
            m_cnt = '0;
            m_ill = 1'b0;
        end else begin
            rdy = (q.size() < DEPTH) && !fl;
            vld = (q.size() > 0) && !fl;
            m_ill = cv && rdy && (op >= 8);
            if (fl) begin
                q.delete();
            end else begin
                if (vld && ir) begin
                    void'(q.pop_front());
                    m_cnt++;
                end
                if (cv && rdy && op < 8)
                    q.push_back(ref_word(op, rd, rs1, rs2));
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(bit ir);
        step(0, 0, 0, 0, 0, 0, 0, ir, 1);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        cmp("rst_empty", 32'(empty_o), 32'd1);
        cmp("rst_valid", 32'(instr_valid_o), 32'd0);
        cmp("rst_count", 32'(count_o), 32'd0);
        cmp("rst_illegal", 32'(illegal_o), 32'd0);

        step(0, 0, 1, 0, 5, 6, 7, 0, 1);
        cmp("add_valid", 32'(instr_valid_o), 32'd1);
        cmp("add_word", instr_rdata_o, 32'hD473028B);
        idle(1);
        cmp("add_count", 32'(count_o), 32'd1);
        cmp("add_empty", 32'(empty_o), 32'd1);

        step(0, 0, 1, 7, 1, 2, 31, 0, 1);
        cmp("p2f_word", instr_rdata_o, 32'hD201008B);
        idle(1);

        for (int i = 0; i < 8; i++)
            step(0, 0, 1, i, i + 1, i + 2, i + 3, 1, 1);
        idle(1);

        for (int i = 0; i < 4; i++)
            step(0, 0, 1, i, 10 + i, 20 + i, 3, 0, 1);
        cmp("full_ready", 32'(cmd_ready_o), 32'd0);
        cmp("full_head", instr_rdata_o, ref_word(0, 10, 20, 3));
        idle(1);
        cmp("pop_ready", 32'(cmd_ready_o), 32'd1);
        cmp("pop_head", instr_rdata_o, ref_word(1, 11, 21, 3));
        for (int i = 0; i < 3; i++)
            idle(1);

        step(0, 0, 1, 9, 1, 1, 1, 1, 1);
        cmp("ill_pulse", 32'(illegal_o), 32'd1);
        cmp("ill_valid", 32'(instr_valid_o), 32'd0);
        cmp("ill_count", 32'(count_o), 32'(m_cnt));
        idle(1);
        cmp("ill_end", 32'(illegal_o), 32'd0);

        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 2, 3, 4, 5, 0, 1);
        step(0, 1, 1, 3, 3, 4, 5, 1, 1);
        cmp("flush_empty", 32'(empty_o), 32'd1);
        cmp("flush_count", 32'(count_o), 32'(m_cnt));

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 15),
                 $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 1) == 1, 1);

        step(0, 1, 0, 0, 0, 0, 0, 0, 1);
        while (m_cnt != 16'hFFFF)
            step(0, 0, 1, $urandom_range(0, 7), 1, 2, 3, 1, 1);
        cmp("cnt_max", 32'(count_o), 32'h0000FFFF);
        idle(1);
        cmp("cnt_wrap", 32'(count_o), 32'd0);

        step(0, 0, 1, 4, 1, 2, 3, 0, 1);
        step(0, 0, 1, 9, 1, 2, 3, 0, 1);
        step(1, 0, 1, 9, 1, 2, 3, 1, 1);
        cmp("mrst_valid", 32'(instr_valid_o), 32'd0);
        cmp("mrst_empty", 32'(empty_o), 32'd1);
        cmp("mrst_count", 32'(count_o), 32'd0);
        cmp("mrst_illegal", 32'(illegal_o), 32'd0);
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
